// File: rtl/msrr_pkg.sv
// -----------------------------------------------------------------------------
// msrr_pkg
// Shared definitions for the msrr_loader serialiser:
//   - downstream mode codes driven on the 2-bit mode bus
//   - FSM state typedef
//   - mode_of(): maps an FSM state to the downstream mode code
// -----------------------------------------------------------------------------
package msrr_pkg;

    // Downstream register mode codes.
    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROT    = 2'b10;
    // Reserved code: the loader never drives it.
    localparam logic [1:0] MODE_SHIFT2 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROT   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The mode bus is a pure function of the state, so it can never glitch on inputs.
    function automatic logic [1:0] mode_of(input state_t st);
        logic [1:0] m;
        case (st)
            ST_SHIFT: m = MODE_SHIFT;
            ST_ROT:   m = MODE_ROT;
            ST_IDLE:  m = MODE_HOLD;
            ST_DONE:  m = MODE_HOLD;
            default:  m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/msrr_loader.sv
// -----------------------------------------------------------------------------
// msrr_loader
// Accepts a parallel WIDTH-bit word and feeds it LSB first into a downstream
// shift register (mode=01, serial bit on sIn), optionally followed by a number
// of downstream rotate cycles (mode=10), then pulses done for one cycle.
//
// Optional feature macro: MSRR_LOADER_ROTATE_EN
//   defined   -> in_rot/rot_cnt select 0..7 rotate cycles after the shift phase
//   undefined -> no rotate phase; in_rot/rot_cnt are accepted but ignored
//
// Ports
//   clk       in   rising-edge clock
//   Re        in   asynchronous active-high reset
//   in_valid  in   parallel word offered
//   in_ready  out  word accepted on this edge when in_valid is also high
//   in_data   in   WIDTH-bit word to serialise
//   in_rot    in   rotate request, sampled with in_data
//   rot_cnt   in   rotate step count (3 bits), sampled with in_data
//   sIn       out  serial bit for the downstream register
//   mode      out  downstream mode: 00 hold, 01 shift-in, 10 rotate
//   busy      out  high whenever not idle
//   done      out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module msrr_loader
    import msrr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Re,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_rot,
    input  logic [2:0]       rot_cnt,
    output logic             sIn,
    output logic [1:0]       mode,
    output logic             busy,
    output logic             done
);

    // One extra bit keeps the counter from wrapping even when WIDTH is a power of two.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

`ifdef MSRR_LOADER_ROTATE_EN
    // Remaining rotate steps; zero at load means "no rotate phase".
    logic [2:0]       rot_q, rot_d;
`else
    // Rotate inputs are part of the interface but have no effect in this build.
    logic             unused_rot_s;
    assign unused_rot_s = ^{in_rot, rot_cnt};
`endif

    // State, buffer and counters; reset acts immediately regardless of clk.
    always_ff @(posedge clk or posedge Re) begin
        if (Re) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
`ifdef MSRR_LOADER_ROTATE_EN
            rot_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
`ifdef MSRR_LOADER_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    // Next-state, buffer and counter logic.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
`ifdef MSRR_LOADER_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    buf_d   = in_data;
                    cnt_d   = '0;
`ifdef MSRR_LOADER_ROTATE_EN
                    // A zero count with in_rot set collapses to "no rotate".
                    rot_d   = in_rot ? rot_cnt : 3'd0;
`endif
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // buf[0] is on sIn this cycle; expose the next bit for the next cycle.
                buf_d = buf_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
`ifdef MSRR_LOADER_ROTATE_EN
                    if (rot_q != 3'd0) begin
                        state_d = ST_ROT;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_SHIFT;
                end
            end
`ifdef MSRR_LOADER_ROTATE_EN
            ST_ROT: begin
                if (rot_q <= 3'd1) begin
                    rot_d   = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    rot_d   = rot_q - 3'd1;
                    state_d = ST_ROT;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign mode     = mode_of(state_q);
    assign sIn      = (state_q == ST_SHIFT) & buf_q[0];

endmodule

// File: tb/tb_msrr_loader.sv
// -----------------------------------------------------------------------------
// tb_msrr_loader
// Directed and randomised checks of msrr_loader. A behavioural downstream
// register follows the mode/sIn bus; expected values come from the transfer
// timeline (WIDTH shift cycles, optional rotate cycles, one done cycle) and a
// plain rotate-right of the offered word.
// -----------------------------------------------------------------------------
module tb_msrr_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         Re;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_rot;
    logic [2:0]   rot_cnt;
    logic         sIn;
    logic [1:0]   mode;
    logic         busy;
    logic         done;

    logic [W-1:0] q_dn = '0;

    int checks   = 0;
    int failures = 0;

    msrr_loader #(.WIDTH(W)) dut (
        .clk      (clk),
        .Re       (Re),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_rot   (in_rot),
        .rot_cnt  (rot_cnt),
        .sIn      (sIn),
        .mode     (mode),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Downstream register: shift-in enters at the MSB so the first bit ends at Q[0].
    always @(posedge clk) begin
        case (mode)
            2'b01:   q_dn <= {sIn, q_dn[W-1:1]};
            2'b10:   q_dn <= {q_dn[0], q_dn[W-1:1]};
            default: q_dn <= q_dn;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_rot(input bit rot, input int rc);
`ifdef MSRR_LOADER_ROTATE_EN
        return (rot && rc != 0) ? rc : 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input int r);
        logic [2*W-1:0] w;
        w = {d, d} >> r;
        return w[W-1:0];
    endfunction

    // vmode: 0 drop valid after transfer, 1 random valid/data noise, 2 hold valid with nxt.
    task automatic run_word(input logic [W-1:0] d, input bit rot, input logic [2:0] rc,
                            input int vmode, input logic [W-1:0] nxt);
        int r;
        r = eff_rot(rot, int'(rc));
        chk("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_rot   = rot;
        rot_cnt  = rc;
        tick();
        if (vmode == 2) begin
            in_data = nxt;
            in_rot  = 1'b0;
            rot_cnt = 3'd0;
        end else begin
            in_valid = 1'b0;
        end
        for (int j = 0; j < W; j++) begin
            chk("shift_mode", mode, 2'b01);
            chk("shift_sin", sIn, d[j]);
            chk("shift_ready", in_ready, 0);
            chk("shift_busy", busy, 1);
            chk("shift_done", done, 0);
            if (vmode == 1) begin
                in_valid = 1'($urandom);
                in_data  = W'($urandom);
                in_rot   = 1'($urandom);
                rot_cnt  = 3'($urandom);
            end
            tick();
        end
        for (int j = 0; j < r; j++) begin
            chk("rot_mode", mode, 2'b10);
            chk("rot_sin", sIn, 0);
            chk("rot_busy", busy, 1);
            tick();
        end
        chk("done_pulse", done, 1);
        chk("done_mode", mode, 2'b00);
        chk("done_ready", in_ready, 0);
        chk("done_busy", busy, 1);
        chk("done_sin", sIn, 0);
        if (vmode != 2) in_valid = 1'b0;
        tick();
        chk("after_ready", in_ready, 1);
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("after_mode", mode, 2'b00);
        chk("downstream_q", q_dn, rotr(d, r));
    endtask

    initial begin
        Re       = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_rot   = 1'b0;
        rot_cnt  = 3'd0;
        #2;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mode, 2'b00);
        chk("rst_sin", sIn, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        Re = 1'b0;

        // First word on the very first edge after reset release.
        run_word(8'hA5, 1'b0, 3'd0, 0, 8'h00);

        // Back-to-back with in_valid held: second word only when ready returns.
        run_word(8'h0F, 1'b0, 3'd0, 2, 8'hF0);
        run_word(8'hF0, 1'b0, 3'd0, 0, 8'h00);

        // Rotate request (active only in the rotate build), and zero-count rotate.
        run_word(8'h81, 1'b1, 3'd3, 0, 8'h00);
        run_word(8'h81, 1'b1, 3'd5, 0, 8'h00);
        run_word(8'h6C, 1'b1, 3'd0, 0, 8'h00);

        // Valid/data noise during the shift phase must not disturb the word.
        run_word(8'h3B, 1'b0, 3'd0, 1, 8'h00);

        // Reset pulse in the 4th SHIFT cycle aborts with no done pulse.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_mode", mode, 2'b01);
        chk("abort_pre_sin", sIn, 1);
        #2;
        Re = 1'b1;
        #1;
        chk("abort_mode", mode, 2'b00);
        chk("abort_busy", busy, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_sin", sIn, 0);
        #1;
        Re = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        run_word(8'h5A, 1'b0, 3'd0, 0, 8'h00);

        // Randomised words.
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] d;
            logic         rt;
            logic [2:0]   rc;
            d  = W'($urandom);
            rt = 1'($urandom);
            rc = 3'($urandom);
            run_word(d, rt, rc, int'($urandom_range(0, 1)), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
